// File: rtl/mips_pkg.sv
// Shared types and defaults for the IF/MEM memory arbiter.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {GRANT_IF, GRANT_MEM} arb_grant_t;

  localparam int unsigned ARB_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one fixed-latency single-port RAM between the IF and MEM pipeline stages.
// Define ROUND_ROBIN_EN to alternate grants on contention; otherwise MEM always wins.
module memory_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned LATENCY    = ARB_LATENCY_DEFAULT,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  output logic                  o_if_valid,
  input  logic                  i_mem_req,
  input  logic                  i_mem_we,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_wdata,
  output logic [DATA_WIDTH-1:0] o_mem_rdata,
  output logic                  o_mem_valid,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic                  o_stall
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  arb_state_t            r_state;
  arb_grant_t            r_grant;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ram_en;
  logic                  r_if_valid;
  logic                  r_mem_valid;
`ifdef ROUND_ROBIN_EN
  arb_grant_t            r_last_grant;
`endif

  arb_grant_t            w_grant;
  logic [DATA_WIDTH-1:0] w_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_grant     <= GRANT_IF;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ram_en    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_last_grant <= GRANT_IF;
`endif
    end else begin
      r_ram_en    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_if_req || i_mem_req) begin
            r_grant  <= w_grant;
            r_we     <= (w_grant == GRANT_MEM) && i_mem_we;
            r_addr   <= (w_grant == GRANT_MEM) ? i_mem_addr : i_if_addr;
            r_wdata  <= (w_grant == GRANT_MEM) ? i_mem_wdata : '0;
            // RAM strobe is registered so it lands in the ISSUE cycle.
            r_ram_en <= 1'b1;
            r_state  <= ISSUE;
`ifdef ROUND_ROBIN_EN
            r_last_grant <= w_grant;
`endif
          end
        end
        ISSUE: begin
          r_cnt <= CNT_W'(LATENCY - 1);
          if (r_we || LATENCY == 1) begin
            r_state     <= DONE;
            r_if_valid  <= (r_grant == GRANT_IF);
            r_mem_valid <= (r_grant == GRANT_MEM);
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= DONE;
            r_if_valid  <= (r_grant == GRANT_IF);
            r_mem_valid <= (r_grant == GRANT_MEM);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_grant = GRANT_IF;
    if (i_mem_req && !i_if_req) begin
      w_grant = GRANT_MEM;
    end else if (i_mem_req && i_if_req) begin
`ifdef ROUND_ROBIN_EN
      w_grant = (r_last_grant == GRANT_MEM) ? GRANT_IF : GRANT_MEM;
`else
      w_grant = GRANT_MEM;
`endif
    end
    // Writes complete with zero data; reads pass RAM data straight through.
    w_rdata     = r_we ? '0 : i_ram_rdata;
    o_if_rdata  = r_if_valid ? w_rdata : '0;
    o_mem_rdata = r_mem_valid ? w_rdata : '0;
    o_stall     = (i_if_req & ~r_if_valid) | (i_mem_req & ~r_mem_valid);
  end

  assign o_if_valid  = r_if_valid;
  assign o_mem_valid = r_mem_valid;
  assign o_ram_en    = r_ram_en;
  assign o_ram_we    = r_we & r_ram_en;
  assign o_ram_addr  = r_addr;
  assign o_ram_wdata = r_wdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed scoreboard bench for memory_arbiter (LATENCY=2 instance plus a LATENCY=1 instance).
module tb_memory_arbiter;
  import mips_pkg::*;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_valid, mem_valid, ram_en, ram_we, stall;

  logic        if_req1, mem_req1, mem_we1;
  logic [31:0] if_addr1, mem_addr1, mem_wdata1;
  logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
  logic        if_valid1, mem_valid1, ram_en1, ram_we1, stall1;

  memory_arbiter #(.LATENCY(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_valid(if_valid),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata), .o_mem_valid(mem_valid),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_stall(stall)
  );

  memory_arbiter #(.LATENCY(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut1 (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req1), .i_if_addr(if_addr1), .o_if_rdata(if_rdata1), .o_if_valid(if_valid1),
    .i_mem_req(mem_req1), .i_mem_we(mem_we1), .i_mem_addr(mem_addr1), .i_mem_wdata(mem_wdata1),
    .o_mem_rdata(mem_rdata1), .o_mem_valid(mem_valid1),
    .o_ram_en(ram_en1), .o_ram_we(ram_we1), .o_ram_addr(ram_addr1), .o_ram_wdata(ram_wdata1),
    .i_ram_rdata(ram_rdata1), .o_stall(stall1)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {16'hC0DE, a[15:0]} ^ 32'h0000_5A5A;
  endfunction

  // RAM models: reads return LATENCY cycles after the strobe, junk otherwise.
  bit   [31:0] mem0 [256];
  bit   [255:0] wr0;
  logic [31:0] p0_a = 32'hBAD0_0000, p0_b = 32'hBAD0_0000;
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem0[ram_addr[9:2]] <= ram_wdata;
      wr0[ram_addr[9:2]]  <= 1'b1;
    end
    p0_a <= (ram_en && !ram_we) ?
            (wr0[ram_addr[9:2]] ? mem0[ram_addr[9:2]] : init_word(ram_addr)) : 32'hBAD0_0000;
    p0_b <= p0_a;
  end
  assign ram_rdata = p0_b;

  bit   [31:0] mem1 [256];
  bit   [255:0] wr1;
  logic [31:0] p1_a = 32'hBAD1_0000;
  always @(posedge clk) begin
    if (ram_en1 && ram_we1) begin
      mem1[ram_addr1[9:2]] <= ram_wdata1;
      wr1[ram_addr1[9:2]]  <= 1'b1;
    end
    p1_a <= (ram_en1 && !ram_we1) ?
            (wr1[ram_addr1[9:2]] ? mem1[ram_addr1[9:2]] : init_word(ram_addr1)) : 32'hBAD1_0000;
  end
  assign ram_rdata1 = p1_a;

  exp_t sb[$];
  exp_t sb1[$];
  bit   model_last_mem = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  function automatic bit pick_mem(input bit if_p, input bit mem_p);
    if (!if_p) return mem_p;
    if (!mem_p) return 1'b0;
`ifdef ROUND_ROBIN_EN
    return !model_last_mem;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
  endtask

  // Waits for a completion on the LATENCY=2 instance and scores it.
  task automatic wait_done(input string tag, input int budget);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      settle();
      if (if_valid || mem_valid) begin
        seen = 1'b1;
        chk1({tag, "_excl"}, if_valid & mem_valid, 1'b0);
        chk1({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk1({tag, "_src"}, mem_valid, e.is_mem);
          chk({tag, "_rdata"}, mem_valid ? mem_rdata : if_rdata, e.data);
          chk({tag, "_cycle"}, 32'(cyc), 32'(e.due));
        end
      end else begin
        step();
      end
    end
    if (!seen) chk1({tag, "_timeout"}, seen, 1'b1);
  endtask

  task automatic dut1_txn(input string tag, input bit is_mem, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data);
    int   t;
    exp_t e;
    step();
    t = cyc;
    if (is_mem) begin
      mem_req1 = 1'b1; mem_we1 = we; mem_addr1 = addr; mem_wdata1 = wdata;
    end else begin
      if_req1 = 1'b1; if_addr1 = addr;
    end
    sb1.push_back('{is_mem: is_mem, data: exp_data, due: t + 2});
    step(); settle();
    chk1({tag, "_ram_en_c1"}, ram_en1, 1'b1);
    chk1({tag, "_ram_we_c1"}, ram_we1, we);
    chk({tag, "_ram_addr_c1"}, ram_addr1, addr);
    step(); settle();
    chk1({tag, "_valid_c2"}, is_mem ? mem_valid1 : if_valid1, 1'b1);
    chk1({tag, "_other_c2"}, is_mem ? if_valid1 : mem_valid1, 1'b0);
    chk1({tag, "_ram_en_c2"}, ram_en1, 1'b0);
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      chk({tag, "_rdata"}, is_mem ? mem_rdata1 : if_rdata1, e.data);
      chk({tag, "_cycle"}, 32'(cyc), 32'(e.due));
    end
    step();
    if_req1 = 1'b0; mem_req1 = 1'b0; mem_we1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit first_mem;

    reset = 1'b1;
    drive_idle();
    if_req1 = 1'b0; if_addr1 = '0; mem_req1 = 1'b0; mem_we1 = 1'b0;
    mem_addr1 = '0; mem_wdata1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    settle();
    chk1("rst_ram_en", ram_en, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_mem_valid", mem_valid, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst1_ram_en", ram_en1, 1'b0);

    // 1: IF read only
    step(); t0 = cyc;
    if_req = 1'b1; if_addr = 32'h40;
    sb.push_back('{is_mem: 1'b0, data: 32'h8C22_0004, due: t0 + 3});
    model_last_mem = 1'b0;
    settle();
    chk1("t1_stall_c0", stall, 1'b1);
    chk1("t1_ram_en_c0", ram_en, 1'b0);
    step(); settle();
    chk1("t1_ram_en_c1", ram_en, 1'b1);
    chk1("t1_ram_we_c1", ram_we, 1'b0);
    chk("t1_ram_addr_c1", ram_addr, 32'h40);
    chk1("t1_stall_c1", stall, 1'b1);
    step(); settle();
    chk1("t1_ram_en_c2", ram_en, 1'b0);
    chk1("t1_stall_c2", stall, 1'b1);
    step();
    wait_done("t1", 4);
    chk1("t1_stall_c3", stall, 1'b0);
    step(); drive_idle();

    // 2: MEM write
    step(); t0 = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    sb.push_back('{is_mem: 1'b1, data: 32'h0, due: t0 + 2});
    model_last_mem = 1'b1;
    settle();
    chk1("t2_stall_c0", stall, 1'b1);
    step(); settle();
    chk1("t2_ram_en_c1", ram_en, 1'b1);
    chk1("t2_ram_we_c1", ram_we, 1'b1);
    chk("t2_ram_addr_c1", ram_addr, 32'h100);
    chk("t2_ram_wdata_c1", ram_wdata, 32'hDEAD_BEEF);
    step();
    wait_done("t2", 4);
    step(); drive_idle();

    // 3: simultaneous IF 0x44 and MEM read 0x200
    step(); t0 = cyc;
    if_req = 1'b1; if_addr = 32'h44;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
    first_mem = pick_mem(1'b1, 1'b1);
    sb.push_back('{is_mem: first_mem,
                   data: first_mem ? init_word(32'h200) : init_word(32'h44), due: t0 + 3});
    sb.push_back('{is_mem: !first_mem,
                   data: first_mem ? init_word(32'h44) : init_word(32'h200), due: t0 + 7});
    model_last_mem = !first_mem;
    step(); settle();
    chk1("t3_ram_en_c1", ram_en, 1'b1);
    chk("t3_ram_addr_c1", ram_addr, first_mem ? 32'h200 : 32'h44);
    step();
    wait_done("t3a", 4);
    step();
    if (first_mem) mem_req = 1'b0;
    else if_req = 1'b0;
    settle();
    chk1("t3_stall_c4", stall, 1'b1);
    chk1("t3_ram_en_c4", ram_en, 1'b0);
    step(); settle();
    chk1("t3_ram_en_c5", ram_en, 1'b1);
    chk("t3_ram_addr_c5", ram_addr, first_mem ? 32'h44 : 32'h200);
    step();
    wait_done("t3b", 4);
    step(); drive_idle();

    // 4: both held high for six grants; MEM reads back the earlier write
    step(); t0 = cyc;
    if_req = 1'b1; if_addr = 32'h44;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      first_mem = pick_mem(1'b1, 1'b1);
      model_last_mem = first_mem;
      sb.push_back('{is_mem: first_mem,
                     data: first_mem ? 32'hDEAD_BEEF : init_word(32'h44), due: t0 + 3 + 4 * k});
      wait_done($sformatf("t4_%0d", k), 6);
      step();
    end
    drive_idle();

    // 5: reset during WAIT aborts the read
    step();
    if_req = 1'b1; if_addr = 32'h40;
    step();
    step(); reset = 1'b1;
    step(); reset = 1'b0; if_req = 1'b0;
    model_last_mem = 1'b0;
    settle();
    chk1("t5_ram_en_after", ram_en, 1'b0);
    chk1("t5_if_valid_after", if_valid, 1'b0);
    chk1("t5_mem_valid_after", mem_valid, 1'b0);
    chk1("t5_stall_after", stall, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(); settle();
      chk1($sformatf("t5_quiet_valid_%0d", k), if_valid | mem_valid, 1'b0);
      chk1($sformatf("t5_quiet_ram_en_%0d", k), ram_en, 1'b0);
    end
    step(); t0 = cyc;
    if_req = 1'b1; if_addr = 32'h44;
    sb.push_back('{is_mem: 1'b0, data: init_word(32'h44), due: t0 + 3});
    step(); settle();
    chk1("t5_fresh_ram_en_c1", ram_en, 1'b1);
    chk("t5_fresh_ram_addr_c1", ram_addr, 32'h44);
    step();
    wait_done("t5_fresh", 4);
    step(); drive_idle();

    // 6: LATENCY=1 instance
    dut1_txn("t6_if", 1'b0, 1'b0, 32'h40, 32'h0, 32'h8C22_0004);
    dut1_txn("t6_wr", 1'b1, 1'b1, 32'h80, 32'h1234_5678, 32'h0);
    dut1_txn("t6_rd", 1'b1, 1'b0, 32'h80, 32'h0, 32'h1234_5678);

    chk("sb_drained", 32'(sb.size() + sb1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
